// File: rtl/dff_stream_deframer.sv
// dff_stream_deframer
//
// Consumes the one-bit-per-cycle output of the upstream D flip-flop stage.
// It hunts for a sync word, then turns the FRAME_WORDS data words that follow
// into parallel words with a one-cycle valid strobe. It also keeps a
// saturating count of completed frames.
//
// Ports:
//   clock_i        sole clock, rising edge
//   reset_i        asynchronous active-high reset
//   bit_i          serial data bit, MSB of each word first
//   enable_i       bit_i is sampled only on edges where this is 1
//   word_o         last assembled data word, held between strobes
//   word_valid_o   one-cycle strobe, word_o is new
//   locked_o       1 while inside a frame (after sync, before last word)
//   frame_done_o   one-cycle strobe alongside the last word of a frame
//   frame_count_o  completed frames, saturating at all-ones
module dff_stream_deframer #(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  SYNC_WORD   = WIDTH'(8'hA5),
  parameter int                FRAME_WORDS = 4,
  parameter int                CNT_W       = 16
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              bit_i,
  input  logic              enable_i,
  output logic [WIDTH-1:0]  word_o,
  output logic              word_valid_o,
  output logic              locked_o,
  output logic              frame_done_o,
  output logic [CNT_W-1:0]  frame_count_o
);

  localparam int BC_W = $clog2(WIDTH);
  localparam int WI_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(WIDTH - 1);
  localparam logic [WI_W-1:0] WORD_LAST = WI_W'(FRAME_WORDS - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  sh_reg, sh_next;
  logic [WIDTH-1:0]  word_reg, word_next;
  logic [BC_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [WI_W-1:0]   word_idx_reg, word_idx_next;
  logic              valid_reg, valid_next;
  logic              done_reg, done_next;
  logic              locked_reg, locked_next;
  logic [CNT_W-1:0]  count_reg, count_next;

  // Shift register value after this edge's bit is taken in. Both the sync
  // compare and the word capture look at it so the decision is made on the
  // same edge that samples the last bit.
  logic [WIDTH-1:0]  shifted;
  assign shifted = {sh_reg[WIDTH-2:0], bit_i};

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg    <= HUNT;
      sh_reg       <= '0;
      word_reg     <= '0;
      bit_cnt_reg  <= '0;
      word_idx_reg <= '0;
      valid_reg    <= 1'b0;
      done_reg     <= 1'b0;
      locked_reg   <= 1'b0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      sh_reg       <= sh_next;
      word_reg     <= word_next;
      bit_cnt_reg  <= bit_cnt_next;
      word_idx_reg <= word_idx_next;
      valid_reg    <= valid_next;
      done_reg     <= done_next;
      locked_reg   <= locked_next;
      count_reg    <= count_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    sh_next       = sh_reg;
    word_next     = word_reg;
    bit_cnt_next  = bit_cnt_reg;
    word_idx_next = word_idx_reg;
    valid_next    = 1'b0;
    done_next     = 1'b0;
    locked_next   = locked_reg;
    count_next    = count_reg;

    if (enable_i) begin
      sh_next = shifted;
      case (state_reg)
        HUNT: begin
          if (shifted == SYNC_WORD) begin
            state_next    = LOCKED;
            bit_cnt_next  = '0;
            word_idx_next = '0;
          end
        end
        LOCKED: begin
          // Sync-like data inside a frame is deliberately not examined here.
          if (bit_cnt_reg == BIT_LAST) begin
            word_next     = shifted;
            valid_next    = 1'b1;
            bit_cnt_next  = '0;
            word_idx_next = word_idx_reg + 1'b1;
            if (word_idx_reg == WORD_LAST) begin
              done_next     = 1'b1;
              state_next    = HUNT;
              // The cleared shift register lets the next sync start with the
              // very next sampled bit, with no stale frame bits in it.
              sh_next       = '0;
              word_idx_next = '0;
              if (count_reg != '1) begin
                count_next = count_reg + 1'b1;
              end
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = HUNT;
        end
      endcase
      // locked_o follows the state being entered. It rises right after the
      // last sync bit and falls together with the final word strobe.
      locked_next = (state_next == LOCKED);
    end
  end

  assign word_o        = word_reg;
  assign word_valid_o  = valid_reg;
  assign locked_o      = locked_reg;
  assign frame_done_o  = done_reg;
  assign frame_count_o = count_reg;

endmodule

// File: tb/tb_dff_stream_deframer.sv
// Testbench for dff_stream_deframer.
// Builds serial bit streams and derives the expected output after every
// sampled bit from a stream-level model: find the sync, then slice the next
// WIDTH*FRAME_WORDS bits into words. It also checks directed timing and
// counter values.
module tb_dff_stream_deframer;

  localparam int         WIDTH   = 8;
  localparam logic [7:0] SYNC    = 8'hA5;
  localparam int         FW      = 4;
  localparam int         CNT_W   = 2;
  localparam int         CNT_MAX = (1 << CNT_W) - 1;
  localparam int         MAXN    = 1024;

  logic              clock_i = 1'b0;
  logic              reset_i;
  logic              bit_i;
  logic              enable_i;
  logic [WIDTH-1:0]  word_o;
  logic              word_valid_o;
  logic              locked_o;
  logic              frame_done_o;
  logic [CNT_W-1:0]  frame_count_o;

  dff_stream_deframer #(
    .WIDTH(WIDTH), .SYNC_WORD(SYNC), .FRAME_WORDS(FW), .CNT_W(CNT_W)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i), .bit_i(bit_i), .enable_i(enable_i),
    .word_o(word_o), .word_valid_o(word_valid_o), .locked_o(locked_o),
    .frame_done_o(frame_done_o), .frame_count_o(frame_count_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int fails  = 0;

  bit   stream[$];
  logic [7:0] ew[MAXN];
  bit   ev[MAXN];
  bit   ed[MAXN];
  bit   el[MAXN];
  int   ec[MAXN];
  int   pos;
  int   step;
  logic [7:0] hw;
  bit   hl;
  int   hc;
  int   strobe_steps[$];
  int   done_counts[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int k = 7; k >= 0; k--) stream.push_back(v[k]);
  endtask

  // Expected outputs after each sampled bit of the stream, counted from reset.
  task automatic analyze();
    int n;
    int i;
    int win;
    int cnt;
    int acc;
    logic [7:0] cur;
    n = stream.size();
    i = 0; win = 0; cnt = 0; acc = 0; cur = 8'h00;
    for (int k = 0; k < n; k++) begin
      ev[k] = 0; ed[k] = 0; el[k] = 0; ew[k] = 8'h00; ec[k] = 0;
    end
    while (i < n) begin
      win = ((win << 1) | int'(stream[i])) & 'hFF;
      ew[i] = cur; ec[i] = cnt;
      if (win == int'(SYNC)) begin
        el[i] = 1;
        for (int b = 0; b < WIDTH * FW && i + 1 + b < n; b++) begin
          int idx;
          idx = i + 1 + b;
          if (b % WIDTH == 0) acc = 0;
          acc = acc * 2 + int'(stream[idx]);
          el[idx] = 1;
          if (b % WIDTH == WIDTH - 1) begin
            cur = acc[7:0];
            ev[idx] = 1;
          end
          if (b == WIDTH * FW - 1) begin
            ed[idx] = 1;
            el[idx] = 0;
            cnt = (cnt < CNT_MAX) ? cnt + 1 : cnt;
          end
          ew[idx] = cur; ec[idx] = cnt;
        end
        i = i + 1 + WIDTH * FW;
        win = 0;
      end else begin
        i++;
      end
    end
  endtask

  task automatic send(input bit b, input bit en);
    bit_i = b;
    enable_i = en;
    @(posedge clock_i);
    #1;
    step++;
    if (word_valid_o === 1'b1) strobe_steps.push_back(step);
    if (frame_done_o === 1'b1) done_counts.push_back(int'(frame_count_o));
    if (en) begin
      chk("valid", word_valid_o, ev[pos]);
      chk("done", frame_done_o, ed[pos]);
      chk("locked", locked_o, el[pos]);
      chk("count", frame_count_o, ec[pos]);
      chk("word", word_o, ew[pos]);
      $display("step %0d bit=%0d valid=%0d word=%02h locked=%0d done=%0d count=%0d",
               step, b, word_valid_o, word_o, locked_o, frame_done_o, frame_count_o);
      hw = ew[pos]; hl = el[pos]; hc = ec[pos];
      pos++;
    end else begin
      chk("gap_valid", word_valid_o, 1'b0);
      chk("gap_done", frame_done_o, 1'b0);
      chk("gap_word", word_o, hw);
      chk("gap_locked", locked_o, hl);
      chk("gap_count", frame_count_o, hc);
      $display("step %0d gap valid=%0d word=%02h locked=%0d count=%0d",
               step, word_valid_o, word_o, locked_o, frame_count_o);
    end
  endtask

  task automatic play();
    for (int k = 0; k < stream.size(); k++) send(stream[k], 1'b1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_word"}, word_o, 8'h00);
    chk({tag, "_valid"}, word_valid_o, 1'b0);
    chk({tag, "_locked"}, locked_o, 1'b0);
    chk({tag, "_done"}, frame_done_o, 1'b0);
    chk({tag, "_count"}, frame_count_o, 0);
  endtask

  // Called one time unit after a rising edge: asserts reset mid-cycle.
  task automatic do_reset();
    #3;
    reset_i = 1'b1;
    #1;
    chk_zero("rst_async");
    repeat (3) begin
      bit_i = 1'($urandom);
      enable_i = 1'($urandom);
      @(posedge clock_i);
      #1;
      chk_zero("rst_hold");
    end
    #2;
    reset_i = 1'b0;
    $display("reset applied and released");
    stream.delete();
    strobe_steps.delete();
    done_counts.delete();
    pos = 0; step = 0; hw = 8'h00; hl = 0; hc = 0;
  endtask

  task automatic push_frame_rand();
    push_byte(SYNC);
    for (int w = 0; w < FW; w++) push_byte(8'($urandom));
  endtask

  initial begin
    reset_i = 1'b0;
    bit_i = 1'b0;
    enable_i = 1'b0;
    @(posedge clock_i);
    #1;

    // Reset behaviour
    do_reset();

    // Basic frame
    push_byte(SYNC); push_byte(8'h12); push_byte(8'h34); push_byte(8'h56); push_byte(8'h78);
    analyze();
    play();
    chk("basic_nstrobe", strobe_steps.size(), 4);
    chk("basic_s0", strobe_steps[0], 16);
    chk("basic_s1", strobe_steps[1], 24);
    chk("basic_s3", strobe_steps[3], 40);
    chk("basic_ndone", done_counts.size(), 1);
    chk("basic_donecnt", done_counts[0], 1);
    chk("basic_word", word_o, 8'h78);
    chk("basic_count", frame_count_o, 1);

    // Misaligned sync, sync-valued data inside the frame
    do_reset();
    stream.push_back(1'b1); stream.push_back(1'b0); stream.push_back(1'b1);
    push_byte(SYNC); push_byte(8'h00); push_byte(8'hFF); push_byte(SYNC); push_byte(8'h3C);
    analyze();
    play();
    chk("mis_nstrobe", strobe_steps.size(), 4);
    chk("mis_s0", strobe_steps[0], 19);
    chk("mis_count", frame_count_o, 1);
    chk("mis_locked", locked_o, 1'b0);
    chk("mis_word", word_o, 8'h3C);

    // Enable gap of 3 cycles in the middle of word 1
    do_reset();
    push_byte(SYNC); push_byte(8'hC3); push_byte(8'h9D); push_byte(8'h01); push_byte(8'hE7);
    analyze();
    for (int k = 0; k < stream.size(); k++) begin
      if (k == 20) begin
        repeat (3) send(1'($urandom), 1'b0);
      end
      send(stream[k], 1'b1);
    end
    chk("gap_nstrobe", strobe_steps.size(), 4);
    chk("gap_s0", strobe_steps[0], 16);
    chk("gap_s1", strobe_steps[1], 27);
    chk("gap_fcount", frame_count_o, 1);

    // Reset in the middle of frame 2
    do_reset();
    push_frame_rand();
    push_byte(SYNC); push_byte(8'h5A); push_byte(8'h66); push_byte(8'h99);
    analyze();
    play();
    chk("mid_locked_before", locked_o, 1'b1);
    chk("mid_count_before", frame_count_o, 1);
    do_reset();
    push_byte(SYNC); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    analyze();
    play();
    chk("mid_count_after", frame_count_o, 1);
    chk("mid_word_after", word_o, 8'h44);

    // Saturation with back-to-back frames
    do_reset();
    repeat (5) push_frame_rand();
    analyze();
    play();
    chk("sat_nstrobe", strobe_steps.size(), 20);
    chk("sat_ndone", done_counts.size(), 5);
    chk("sat_c0", done_counts[0], 1);
    chk("sat_c1", done_counts[1], 2);
    chk("sat_c2", done_counts[2], 3);
    chk("sat_c3", done_counts[3], 3);
    chk("sat_c4", done_counts[4], 3);

    // Random idle bits, random data and random enable
    do_reset();
    repeat (3) begin
      int idle;
      idle = int'($urandom_range(0, 12));
      for (int k = 0; k < idle; k++) stream.push_back(1'($urandom));
      push_frame_rand();
    end
    analyze();
    begin
      int k;
      k = 0;
      while (k < stream.size()) begin
        if ($urandom_range(0, 3) != 0) begin
          send(stream[k], 1'b1);
          k++;
        end else begin
          send(1'($urandom), 1'b0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dff_stream_deframer.md
# dff_stream_deframer

Serial-stream consumer that sits directly downstream of the D flip-flop stage and takes its registered output as a one-bit-per-cycle data stream. It hunts for a fixed sync word, deserializes the following fixed-length frame into parallel words with a one-cycle valid strobe, and counts completed frames. It gives the flop stage's testbench a structured, checkable output instead of a bare bit.

## Interface

Parameters:

- WIDTH, 8, word width in bits (≥2)
- SYNC_WORD, 8'hA5, sync pattern, WIDTH bits, received MSB first
- FRAME_WORDS, 4, data words per frame after sync (≥1)
- CNT_W, 16, width of frame counter

Ports:

- clock_i  input  1  sole clock; rising-edge
- reset_i  input  1  asynchronous, active-high reset
- bit_i  input  1  serial data bit; connects to flop stage q_o
- enable_i  input  1  bit_i is sampled only on edges where enable_i=1
- word_o  output  WIDTH  last assembled data word
- word_valid_o  output  1  one-cycle strobe, word_o is new
- locked_o  output  1  1 while inside a frame (post-sync)
- frame_done_o  output  1  one-cycle strobe on last word of frame
- frame_count_o  output  CNT_W  completed frames, saturating

## Operation

- Two states: HUNT, LOCKED. Reset state: HUNT.
- Reset values: all outputs 0; shift register 0; bit counter 0; word index 0.
- Bit order: MSB first; shift register `sh <= {sh[WIDTH-2:0], bit_i}` on every enabled edge in both states.
- HUNT:
  - On each enabled edge, compare the next shift value with SYNC_WORD.
  - On a match, go to LOCKED; clear the bit counter and word index. Sync may start at any bit alignment.
- LOCKED:
  - The bit counter increments per enabled edge.
  - On the edge that samples the WIDTH-th bit:
    - word_o <= assembled word; word_valid_o=1; bit counter <= 0; word index++.
  - If that word is word FRAME_WORDS:
    - frame_done_o=1 on the same cycle as word_valid_o.
    - Return to HUNT; shift register cleared to 0.
    - frame_count_o increments, holding at all-ones (no wrap).
- Data words equal to SYNC_WORD inside a frame are data. No resync occurs while LOCKED.
- enable_i=0: no state, counter or shift update; strobes are 0; word_o, locked_o and frame_count_o hold.
- Reset asserted at any time, including mid-word or mid-frame:
  - All state and outputs go to reset values immediately, without waiting for a clock edge.
  - A partial frame is discarded and not counted.
- word_o holds its last value between strobes.

## Timing

- All outputs are registered and change only on the rising edge of clock_i or on reset assertion.
- locked_o rises the cycle after the edge that samples the last sync bit.
- The first data bit (word 0 MSB) is sampled on the next enabled edge.
- word_valid_o is high for exactly the one cycle following the edge that samples a word's last bit.
- With enable_i held high, strobes are exactly WIDTH cycles apart.
- On the final word:
  - locked_o falls and frame_done_o pulses in the same cycle as the final word_valid_o.
  - frame_count_o updates in that same cycle.
- With enable_i=1, HUNT may detect a new sync starting with the first bit sampled after returning to HUNT. Back-to-back frames need no idle bits.
- End-to-end latency from d_in of the flop stage:
  - One cycle through the flop, then WIDTH sampled bits, then one register cycle to word_valid_o.

## Test plan

- **Reset:** assert reset_i mid-cycle with random bit_i. Required: every output is 0 asynchronously and stays 0 while reset is held.
- **Basic frame:** enable_i=1; send A5, 12, 34, 56, 78 MSB first. Required:
  - locked_o=1 after the 8th bit.
  - word_valid_o pulses 4 times, 8 cycles apart, with word_o=12, 34, 56, 78.
  - frame_done_o coincides with the 78 strobe; locked_o returns to 0; frame_count_o=1.
- **Misaligned sync:** send bits 101 before A5, then a frame of 00, FF, A5, 3C. Required: lock at the A5 after the prefix; A5 in the frame is output as data with no relock; frame_count_o=1.
- **Enable gaps:** drop enable_i for 3 cycles in the middle of word 1. Required: word 1 value is correct and its strobe arrives 3 cycles later than in the no-gap case; no strobe occurs during the gap.
- **Reset mid-frame:** assert reset_i after word 2 of frame 2. Required: locked_o=0 and frame_count_o=0 immediately; a following full frame decodes correctly and frame_count_o=1.
- **Saturation and back-to-back:** with CNT_W=2, send 5 back-to-back frames with no idle bits. Required: all 20 words are correct; frame_count_o reads 1, 2, 3, 3, 3.
